// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubble insertion and data-memory handshake.
// Optional build macro PIPE_STALL_CNT_EN adds stall_cycles and bubble_count.
//
// Ports:
//   clock, reset_n        clock and synchronous active-low reset
//   rs_valid_d0           decode stage holds a valid instruction
//   rs1_d0, rs2_d0        decode-stage source registers
//   opcode_d1, rd_d1      execute-stage opcode and destination
//   register_we_d1        execute-stage register write enable
//   opcode_d2             memory-stage opcode
//   mem_ready             data memory completes its access this cycle
//   fetch_en              PC/fetch register advance enable
//   decode_en             d0->d1 register load enable
//   bubble_d1             load a NOP into d1
//   stage2_en             d1->d2 register load enable
//   mem_req               data memory request for the d2 instruction
//   mem_timeout_err       sticky memory timeout flag
//   ctrl_state            current FSM state (debug)
//   stall_cycles          cycles with stage2_en low (PIPE_STALL_CNT_EN only)
//   bubble_count          bubbles inserted (PIPE_STALL_CNT_EN only)
module pipeline_hazard_ctrl #(
  parameter logic [5:0] LOAD_OPCODE  = 6'b100011,
  parameter logic [5:0] STORE_OPCODE = 6'b101011,
  parameter int         MEM_TIMEOUT  = 16,
  parameter int         CNT_W        = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rs_valid_d0,
  input  logic [4:0]  rs1_d0,
  input  logic [4:0]  rs2_d0,
  input  logic [5:0]  opcode_d1,
  input  logic [4:0]  rd_d1,
  input  logic        register_we_d1,
  input  logic [5:0]  opcode_d2,
  input  logic        mem_ready,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        bubble_d1,
  output logic        stage2_en,
  output logic        mem_req,
  output logic        mem_timeout_err,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [15:0] bubble_count,
`endif
  output logic [1:0]  ctrl_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             mem_op_d2;
  logic             load_use;
  logic             run;

  assign mem_op_d2 = (opcode_d2 == LOAD_OPCODE) |
                     (opcode_d2 == STORE_OPCODE);

  assign load_use = (opcode_d1 == LOAD_OPCODE) &
                    register_we_d1 &
                    (rd_d1 != 5'd0) &
                    rs_valid_d0 &
                    ((rs1_d0 == rd_d1) | (rs2_d0 == rd_d1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    run       = 1'b0;
    mem_req   = 1'b0;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    bubble_d1 = 1'b0;
    stage2_en = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req = mem_op_d2;
        if (mem_op_d2 && !mem_ready) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          run = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          run     = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // The bubble only ever accompanies an advancing d1->d2 register.
    if (run) begin
      unique case (1'b1)
        load_use: begin
          bubble_d1 = 1'b1;
          stage2_en = 1'b1;
        end
        default: begin
          fetch_en  = 1'b1;
          decode_en = 1'b1;
          stage2_en = 1'b1;
        end
      endcase
    end
    // Reset forces every output low in the same cycle.
    if (!reset_n) begin
      mem_req   = 1'b0;
      fetch_en  = 1'b0;
      decode_en = 1'b0;
      bubble_d1 = 1'b0;
      stage2_en = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_timeout_err = reset_n & err_q;
  assign ctrl_state      = reset_n ? state_q : IDLE;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] bub_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_q <= '0;
      bub_q   <= '0;
    end else begin
      if (!stage2_en && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (bubble_d1 && bub_q != '1)
        bub_q <= bub_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bub_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Directed scenarios plus a randomized run against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] LOAD  = 6'b100011;
  localparam logic [5:0] STORE = 6'b101011;
  localparam int         TMO   = 16;

  logic       clock;
  logic       reset_n;
  logic       rs_valid_d0;
  logic [4:0] rs1_d0, rs2_d0, rd_d1;
  logic [5:0] opcode_d1, opcode_d2;
  logic       register_we_d1, mem_ready;
  logic       fetch_en, decode_en, bubble_d1, stage2_en;
  logic       mem_req, mem_timeout_err;
  logic [1:0] ctrl_state;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] bubble_count;
`endif

  int checks = 0;
  int failures = 0;

  // Model state: error flag and number of unanswered request cycles.
  bit      m_err;
  int      m_wait;
  longint  m_stall;
  int      m_bub;
  logic [7:0] exp;

  pipeline_hazard_ctrl dut (
    .clock(clock),
    .reset_n(reset_n),
    .rs_valid_d0(rs_valid_d0),
    .rs1_d0(rs1_d0),
    .rs2_d0(rs2_d0),
    .opcode_d1(opcode_d1),
    .rd_d1(rd_d1),
    .register_we_d1(register_we_d1),
    .opcode_d2(opcode_d2),
    .mem_ready(mem_ready),
    .fetch_en(fetch_en),
    .decode_en(decode_en),
    .bubble_d1(bubble_d1),
    .stage2_en(stage2_en),
    .mem_req(mem_req),
    .mem_timeout_err(mem_timeout_err),
`ifdef PIPE_STALL_CNT_EN
    .stall_cycles(stall_cycles),
    .bubble_count(bubble_count),
`endif
    .ctrl_state(ctrl_state)
  );

  wire [7:0] obs = {fetch_en, decode_en, bubble_d1, stage2_en,
                    mem_req, mem_timeout_err, ctrl_state};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] model_out();
    bit memop, lu, pending, req, go;
    if (!reset_n) return 8'h00;
    if (m_err) return 8'h06;
    memop = (opcode_d2 == LOAD) || (opcode_d2 == STORE);
    lu = (opcode_d1 == LOAD) && register_we_d1 && rd_d1 != 0 &&
         rs_valid_d0 && (rs1_d0 == rd_d1 || rs2_d0 == rd_d1);
    pending = m_wait > 0;
    req = pending || memop;
    go = !req || mem_ready;
    return {go && !lu, go && !lu, go && lu, go,
            req, 1'b0, 1'b0, pending};
  endfunction

  task automatic model_advance();
    logic [7:0] e;
    e = model_out();
    if (!reset_n) begin
      m_err = 0; m_wait = 0; m_stall = 0; m_bub = 0;
    end else begin
      if (!e[4] && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e[5] && m_bub < 16'hFFFF) m_bub++;
      if (!m_err) begin
        if (e[3] && !mem_ready) begin
          m_wait++;
          if (m_wait >= TMO) begin m_err = 1; m_wait = 0; end
        end else begin
          m_wait = 0;
        end
      end
    end
  endtask

  task automatic step();
    model_advance();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    rs_valid_d0 = 0; rs1_d0 = 0; rs2_d0 = 0;
    opcode_d1 = 0; rd_d1 = 0; register_we_d1 = 0;
    opcode_d2 = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    opcode_d2 = LOAD;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) reset_n = 1;
      if (i == 4) mem_ready = 1;
      exp = (i < 3) ? 8'h00 : (i == 3) ? 8'h08 : 8'hD9;
      @(negedge clock);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset c%0d got=%b exp=%b", i, obs, exp);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    idle_inputs();
    opcode_d1 = LOAD; rd_d1 = 5; register_we_d1 = 1;
    rs1_d0 = 5; rs2_d0 = 7; rs_valid_d0 = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) opcode_d1 = 0;
      if (i == 2) begin opcode_d1 = LOAD; rd_d1 = 0; rs1_d0 = 0; end
      exp = (i == 0) ? 8'h30 : 8'hD0;
      @(negedge clock);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL load_use c%0d got=%b exp=%b", i, obs, exp);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    idle_inputs();
    opcode_d2 = STORE;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 3);
      if (i == 4) opcode_d2 = 0;
      exp = (i == 0) ? 8'h08 : (i < 3) ? 8'h09 :
            (i == 3) ? 8'hD9 : 8'hD0;
      @(negedge clock);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL mem_wait c%0d got=%b exp=%b", i, obs, exp);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      opcode_d2 = (i == 0) ? STORE : (i < 4) ? LOAD : 6'd0;
      mem_ready = (i != 1);
      exp = (i == 0) ? 8'hD8 : (i == 1) ? 8'h08 :
            (i == 2) ? 8'hD9 : (i == 3) ? 8'hD8 : 8'hD0;
      @(negedge clock);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL b2b c%0d got=%b exp=%b", i, obs, exp);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_stall_hazard();
    idle_inputs();
    opcode_d1 = LOAD; rd_d1 = 9; register_we_d1 = 1;
    rs2_d0 = 9; rs_valid_d0 = 1; opcode_d2 = LOAD;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 2);
      if (i == 3) begin opcode_d1 = 0; opcode_d2 = 0; end
      exp = (i == 0) ? 8'h08 : (i == 1) ? 8'h09 :
            (i == 2) ? 8'h39 : 8'hD0;
      @(negedge clock);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL stall_hazard c%0d got=%b exp=%b", i, obs, exp);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    idle_inputs();
    opcode_d2 = LOAD;
    for (int i = 0; i < 21; i++) begin
      if (i == 19) reset_n = 0;
      if (i == 20) begin reset_n = 1; opcode_d2 = 0; end
      exp = (i == 0) ? 8'h08 : (i < TMO) ? 8'h09 :
            (i < 19) ? 8'h06 : (i == 19) ? 8'h00 : 8'hD0;
      @(negedge clock);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL timeout c%0d got=%b exp=%b", i, obs, exp);
      end
      step();
    end
    idle_inputs();
  endtask

`ifdef PIPE_STALL_CNT_EN
  task automatic test_counters();
    idle_inputs();
    reset_n = 0;
    step();
    reset_n = 1;
    step();
    opcode_d2 = STORE;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      step();
    end
    idle_inputs();
    opcode_d1 = LOAD; rd_d1 = 5; register_we_d1 = 1;
    rs1_d0 = 5; rs_valid_d0 = 1;
    step();
    idle_inputs();
    @(negedge clock);
    checks++;
    if (stall_cycles !== 32'd3 || bubble_count !== 16'd1) begin
      failures++;
      $display("FAIL counters got=%0d/%0d exp=3/1",
               stall_cycles, bubble_count);
    end
    step();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      rs_valid_d0 = $urandom_range(0, 3) != 0;
      rs1_d0 = 5'($urandom_range(0, 3));
      rs2_d0 = 5'($urandom_range(0, 3));
      rd_d1 = 5'($urandom_range(0, 3));
      register_we_d1 = $urandom_range(0, 3) != 0;
      opcode_d1 = $urandom_range(0, 1) ? LOAD : 6'($urandom);
      case ($urandom_range(0, 3))
        0: opcode_d2 = LOAD;
        1: opcode_d2 = STORE;
        default: opcode_d2 = 6'($urandom_range(0, 7));
      endcase
      mem_ready = $urandom_range(0, 9) < 7;
      @(negedge clock);
      exp = model_out();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random c%0d got=%b exp=%b", i, obs, exp);
      end
`ifdef PIPE_STALL_CNT_EN
      checks++;
      if (stall_cycles !== 32'(m_stall) ||
          bubble_count !== 16'(m_bub)) begin
        failures++;
        $display("FAIL rand_cnt c%0d got=%0d/%0d exp=%0d/%0d", i,
                 stall_cycles, bubble_count, m_stall, m_bub);
      end
`endif
      step();
    end
    idle_inputs();
  endtask

  initial begin
    m_err = 0; m_wait = 0; m_stall = 0; m_bub = 0;
    reset_n = 0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_back_to_back();
    test_stall_hazard();
    test_timeout();
`ifdef PIPE_STALL_CNT_EN
    test_counters();
`endif
    reset_n = 0;
    step();
    reset_n = 1;
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
